// File: rtl/output_arb_pp.sv
// Ping-pong output arbiter: NREQ requesters fill one FIFO bank round-robin while
// the other bank drains downstream; polarity swaps the write/read roles.

module output_arb_pp_bank #(
  parameter int DW    = 64,
  parameter int DEPTH = 2,
  parameter int CW    = 2,
  parameter int PW    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] head,
  output logic [CW-1:0] cnt
);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic          do_wr, do_rd;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign do_wr = wr_en && (cnt != CW'(DEPTH));
  assign do_rd = rd_en && (cnt != '0);
  assign head  = mem[rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (do_wr) begin
      wp  <= inc(wp);
      cnt <= cnt + CW'(1);
    end else if (do_rd) begin
      rp  <= inc(rp);
      cnt <= cnt - CW'(1);
    end
  end

  // Storage is not cleared by reset; the zeroed counts make it unreachable.
  always_ff @(posedge clk) begin
    if (rst && do_wr) mem[wp] <= wr_data;
  end
endmodule

module output_arb_pp #(
  parameter int DW    = 64,
  parameter int NREQ  = 4,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         polarity,
  input  logic                         path_rdy,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*DW-1:0]           din,
  output logic [NREQ-1:0]              gnt,
  output logic [DW-1:0]                dout,
  output logic                         dout_vld,
  output logic [$clog2(DEPTH+1)-1:0]   cnt0,
  output logic [$clog2(DEPTH+1)-1:0]   cnt1
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]        rr_ptr, gnt_idx, scan_idx;
  logic                 gnt_any;
  logic                 wb, rb;
  logic [DW-1:0]        wr_data;
  logic [1:0]           wr_en, rd_en;
  logic [1:0][DW-1:0]   head;
  logic [1:0][CW-1:0]   cnt;

  // polarity=1: write bank0 / read bank1
  assign wb = ~polarity;
  assign rb = polarity;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    if (cnt[wb] < CW'(DEPTH)) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = IW'((int'(rr_ptr) + k) % NREQ);
        if (!gnt_any && req[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    wr_data = din[int'(gnt_idx)*DW +: DW];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rr_ptr <= '0;
    else if (gnt_any)
      rr_ptr <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
  end

  assign dout_vld = path_rdy && (cnt[rb] != '0);
  assign dout     = dout_vld ? head[rb] : '0;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign wr_en[b] = gnt_any && (wb == 1'(b));
    assign rd_en[b] = dout_vld && (rb == 1'(b));
    output_arb_pp_bank #(.DW(DW), .DEPTH(DEPTH), .CW(CW), .PW(PW)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[b]),
      .wr_data (wr_data),
      .rd_en   (rd_en[b]),
      .head    (head[b]),
      .cnt     (cnt[b])
    );
  end

  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
endmodule
